// File: rtl/bt_cmd_rx_if.sv
// Serial command link between a Bluetooth UART source and the command receiver.
// The master side drives the serial line; the slave side (receiver) returns the decoded outputs.
interface bt_cmd_rx_if;
  logic       rx;
  logic [4:0] instruction;
  logic [2:0] turn_angle;
  logic       frame_ok;
  logic       frame_err;
  logic       link_ok;

  modport master (
    output rx,
    input  instruction,
    input  turn_angle,
    input  frame_ok,
    input  frame_err,
    input  link_ok
  );

  modport slave (
    input  rx,
    output instruction,
    output turn_angle,
    output frame_ok,
    output frame_err,
    output link_ok
  );
endinterface

// File: rtl/bt_cmd_rx.sv
// UART receiver plus 3-byte frame parser (A5, cmd, ~cmd) driving motor command outputs.
// Define BT_RX_WATCHDOG_EN to drop the link and zero the outputs after TIMEOUT_CYC idle cycles.
module bt_cmd_rx #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned BAUD        = 9600,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  bt_cmd_rx_if.slave bt_if
);

  localparam int unsigned BitCyc  = CLK_HZ / BAUD;
  localparam int unsigned CntW    = (BitCyc > 2) ? $clog2(BitCyc) : 1;
  localparam logic [CntW-1:0] HalfCnt = CntW'(BitCyc / 2);
  localparam logic [CntW-1:0] LastCnt = CntW'(BitCyc - 1);
  localparam logic [7:0] Header = 8'hA5;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_st_e;
  typedef enum logic [1:0] {StHunt, StHdr, StCmd} parse_st_e;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  uart_st_e        uart_st_q, uart_st_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid, stop_err;

  parse_st_e       parse_st_q, parse_st_d;
  logic [7:0]      cmd_q, cmd_d;
  logic            accept, reject;

  logic [4:0]      instruction_q, instruction_d;
  logic [2:0]      turn_angle_q, turn_angle_d;
  logic            frame_ok_q, frame_ok_d;
  logic            frame_err_q, frame_err_d;
  logic            link_ok_q, link_ok_d;

  // Synchronizer resets to idle-high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bt_if.rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uart_st_q <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      uart_st_q <= uart_st_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    uart_st_d  = uart_st_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    stop_err   = 1'b0;
    unique case (uart_st_q)
      StIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          uart_st_d = StStart;
          cnt_d     = '0;
        end
      end
      StStart: begin
        // Mid-start-bit check; a high line here was only a glitch.
        if (cnt_q == HalfCnt) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          uart_st_d = rx_sync_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == LastCnt) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) uart_st_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == LastCnt) begin
          cnt_d     = '0;
          uart_st_d = StIdle;
          if (rx_sync_q) byte_valid = 1'b1;
          else           stop_err   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: uart_st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parse_st_q <= StHunt;
      cmd_q      <= '0;
    end else begin
      parse_st_q <= parse_st_d;
      cmd_q      <= cmd_d;
    end
  end

  always_comb begin
    parse_st_d = parse_st_q;
    cmd_d      = cmd_q;
    accept     = 1'b0;
    reject     = 1'b0;
    if (stop_err) begin
      parse_st_d = StHunt;
      reject     = 1'b1;
    end else if (byte_valid) begin
      unique case (parse_st_q)
        StHunt: if (shift_q == Header) parse_st_d = StHdr;
        StHdr: begin
          cmd_d      = shift_q;
          parse_st_d = StCmd;
        end
        StCmd: begin
          if (shift_q == ~cmd_q) accept = 1'b1;
          else                   reject = 1'b1;
          parse_st_d = StHunt;
        end
        default: parse_st_d = StHunt;
      endcase
    end
  end

`ifdef BT_RX_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT_CYC);

  logic [WdW-1:0] wd_q, wd_d;
  logic           wd_expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wd_q <= '0;
    else      wd_q <= wd_d;
  end

  always_comb begin
    wd_d = wd_q;
    if (accept)              wd_d = '0;
    else if (wd_q != WdLimit) wd_d = wd_q + WdW'(1);
    wd_expired = (wd_d == WdLimit);
  end

  // Expiry forces a safe stop/straight command in the same cycle the link drops.
  always_comb begin
    frame_ok_d    = accept;
    frame_err_d   = reject;
    instruction_d = accept ? cmd_q[4:0] : instruction_q;
    turn_angle_d  = accept ? cmd_q[7:5] : turn_angle_q;
    link_ok_d     = link_ok_q | accept;
    if (wd_expired) begin
      instruction_d = '0;
      turn_angle_d  = '0;
      link_ok_d     = 1'b0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;

  always_comb begin
    frame_ok_d    = accept;
    frame_err_d   = reject;
    instruction_d = accept ? cmd_q[4:0] : instruction_q;
    turn_angle_d  = accept ? cmd_q[7:5] : turn_angle_q;
    link_ok_d     = link_ok_q | accept;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction_q <= '0;
      turn_angle_q  <= '0;
      frame_ok_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      link_ok_q     <= 1'b0;
    end else begin
      instruction_q <= instruction_d;
      turn_angle_q  <= turn_angle_d;
      frame_ok_q    <= frame_ok_d;
      frame_err_q   <= frame_err_d;
      link_ok_q     <= link_ok_d;
    end
  end

  assign bt_if.instruction = instruction_q;
  assign bt_if.turn_angle  = turn_angle_q;
  assign bt_if.frame_ok    = frame_ok_q;
  assign bt_if.frame_err   = frame_err_q;
  assign bt_if.link_ok     = link_ok_q;

endmodule

// File: tb/tb_bt_cmd_rx.sv
// Directed bench for bt_cmd_rx with a shortened bit period (16 clk per bit) and TIMEOUT_CYC=1000.
// Watchdog checks follow BT_RX_WATCHDOG_EN; otherwise the hold-forever behaviour is checked.
module tb_bt_cmd_rx;
  localparam int unsigned BitCyc = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bt_cmd_rx_if bt_if ();

  bt_cmd_rx #(
    .CLK_HZ      (1_600_000),
    .BAUD        (100_000),
    .TIMEOUT_CYC (1000)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bt_if (bt_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int ok0, err0;
  int unsigned cyc = 0;
  int unsigned ok_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bt_if.frame_ok) begin
      ok_cnt = ok_cnt + 1;
      ok_cyc = cyc;
    end
    if (bt_if.frame_err) err_cnt = err_cnt + 1;
    if (bt_if.frame_ok && bt_if.frame_err) both_cnt = both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bt_if.rx = 1'b0;
    repeat (BitCyc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bt_if.rx = b[i];
      repeat (BitCyc) @(negedge clk);
    end
    bt_if.rx = stop_bit;
    repeat (BitCyc) @(negedge clk);
    bt_if.rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic snap();
    ok0  = ok_cnt;
    err0 = err_cnt;
  endtask

  initial begin
    bt_if.rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_instruction", 32'(bt_if.instruction), 32'h00);
    chk("rst_turn_angle", 32'(bt_if.turn_angle), 32'h0);
    chk("rst_frame_ok", 32'(bt_if.frame_ok), 32'h0);
    chk("rst_frame_err", 32'(bt_if.frame_err), 32'h0);
    chk("rst_link_ok", 32'(bt_if.link_ok), 32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Basic valid frame
    snap();
    send_byte(8'hA5, 1'b1); send_byte(8'h0A, 1'b1); send_byte(8'hF5, 1'b1);
    chk("f1_ok_pulses", 32'(ok_cnt - ok0), 32'd1);
    chk("f1_err_pulses", 32'(err_cnt - err0), 32'd0);
    chk("f1_instruction", 32'(bt_if.instruction), 32'h0A);
    chk("f1_turn_angle", 32'(bt_if.turn_angle), 32'h0);
    chk("f1_link_ok", 32'(bt_if.link_ok), 32'h1);

    // WAVE command with steering
    snap();
    send_byte(8'hA5, 1'b1); send_byte(8'h5A, 1'b1); send_byte(8'hA5, 1'b1);
    chk("f2_ok_pulses", 32'(ok_cnt - ok0), 32'd1);
    chk("f2_instruction", 32'(bt_if.instruction), 32'h1A);
    chk("f2_turn_angle", 32'(bt_if.turn_angle), 32'h2);

    // Bad checksum leaves outputs untouched
    snap();
    send_byte(8'hA5, 1'b1); send_byte(8'h5A, 1'b1); send_byte(8'hA4, 1'b1);
    chk("f3_err_pulses", 32'(err_cnt - err0), 32'd1);
    chk("f3_ok_pulses", 32'(ok_cnt - ok0), 32'd0);
    chk("f3_instruction", 32'(bt_if.instruction), 32'h1A);
    chk("f3_turn_angle", 32'(bt_if.turn_angle), 32'h2);

    // Junk byte, then A5 taken as cmd
    snap();
    send_byte(8'h00, 1'b1); send_byte(8'hA5, 1'b1);
    send_byte(8'hA5, 1'b1); send_byte(8'h5A, 1'b1);
    chk("f4_ok_pulses", 32'(ok_cnt - ok0), 32'd1);
    chk("f4_err_pulses", 32'(err_cnt - err0), 32'd0);
    chk("f4_instruction", 32'(bt_if.instruction), 32'h05);
    chk("f4_turn_angle", 32'(bt_if.turn_angle), 32'h5);

    // Short low glitch on the idle line
    snap();
    bt_if.rx = 1'b0;
    repeat (3) @(negedge clk);
    bt_if.rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_ok_pulses", 32'(ok_cnt - ok0), 32'd0);
    chk("glitch_err_pulses", 32'(err_cnt - err0), 32'd0);
    chk("glitch_instruction", 32'(bt_if.instruction), 32'h05);

    // Stop bit low mid-frame: error, and parser must be back in HUNT
    snap();
    send_byte(8'hA5, 1'b1); send_byte(8'h12, 1'b0);
    chk("stop0_err_pulses", 32'(err_cnt - err0), 32'd1);
    chk("stop0_ok_pulses", 32'(ok_cnt - ok0), 32'd0);
    snap();
    send_byte(8'h0A, 1'b1); send_byte(8'hF5, 1'b1);
    chk("hunt_ok_pulses", 32'(ok_cnt - ok0), 32'd0);
    chk("hunt_err_pulses", 32'(err_cnt - err0), 32'd0);

    // Link hold / watchdog
    snap();
    send_byte(8'hA5, 1'b1); send_byte(8'h0A, 1'b1); send_byte(8'hF5, 1'b1);
    chk("f5_ok_pulses", 32'(ok_cnt - ok0), 32'd1);
`ifdef BT_RX_WATCHDOG_EN
    while (cyc < ok_cyc + 999) @(negedge clk);
    chk("wd_hold_link_ok", 32'(bt_if.link_ok), 32'h1);
    chk("wd_hold_instruction", 32'(bt_if.instruction), 32'h0A);
    @(negedge clk);
    chk("wd_exp_link_ok", 32'(bt_if.link_ok), 32'h0);
    chk("wd_exp_instruction", 32'(bt_if.instruction), 32'h00);
    chk("wd_exp_turn_angle", 32'(bt_if.turn_angle), 32'h0);
    send_byte(8'hA5, 1'b1); send_byte(8'h0A, 1'b1); send_byte(8'hF5, 1'b1);
    chk("wd_restore_link_ok", 32'(bt_if.link_ok), 32'h1);
    chk("wd_restore_instruction", 32'(bt_if.instruction), 32'h0A);
`else
    repeat (1100) @(negedge clk);
    chk("hold_link_ok", 32'(bt_if.link_ok), 32'h1);
    chk("hold_instruction", 32'(bt_if.instruction), 32'h0A);
    chk("hold_turn_angle", 32'(bt_if.turn_angle), 32'h0);
`endif

    // Reset in the middle of byte1
    send_byte(8'hA5, 1'b1);
    bt_if.rx = 1'b0;
    repeat (BitCyc) @(negedge clk);
    bt_if.rx = 1'b1;
    repeat (BitCyc) @(negedge clk);
    bt_if.rx = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst_instruction", 32'(bt_if.instruction), 32'h00);
    chk("mrst_turn_angle", 32'(bt_if.turn_angle), 32'h0);
    chk("mrst_link_ok", 32'(bt_if.link_ok), 32'h0);
    chk("mrst_frame_ok", 32'(bt_if.frame_ok), 32'h0);
    bt_if.rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    snap();
    send_byte(8'hA5, 1'b1); send_byte(8'h0A, 1'b1); send_byte(8'hF5, 1'b1);
    chk("post_ok_pulses", 32'(ok_cnt - ok0), 32'd1);
    chk("post_err_pulses", 32'(err_cnt - err0), 32'd0);
    chk("post_instruction", 32'(bt_if.instruction), 32'h0A);
    chk("post_link_ok", 32'(bt_if.link_ok), 32'h1);

    chk("ok_err_overlap", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
